// File: rtl/signal_pkg.sv
// Shared types and default timings for the signal_phase_ctrl intersection controller.
package signal_pkg;

  typedef enum logic [1:0] {
    S_ALLRED = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_WALK   = 2'd3
  } state_t;

  localparam int DEF_NUM_APP   = 4;
  localparam int DEF_CNT_W     = 8;
  localparam int DEF_GREEN_MIN = 8;
  localparam int DEF_GREEN_MAX = 24;
  localparam int DEF_YELLOW_T  = 3;
  localparam int DEF_ALLRED_T  = 2;
  localparam int DEF_WALK_T    = 10;

endpackage

// File: rtl/phase_timer.sv
// Up-counter that measures cycles spent in the current controller state.
// Synchronous clear has priority over counting; the count holds once it reaches limit.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q < limit)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/signal_phase_ctrl.sv
// Demand-driven round-robin intersection controller with min/max green and gap-out.
// Define PED_PHASE_EN to include the latched pedestrian request and exclusive walk phase.
module signal_phase_ctrl
  import signal_pkg::*;
#(
  parameter int NUM_APP   = DEF_NUM_APP,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int GREEN_MIN = DEF_GREEN_MIN,
  parameter int GREEN_MAX = DEF_GREEN_MAX,
  parameter int YELLOW_T  = DEF_YELLOW_T,
  parameter int ALLRED_T  = DEF_ALLRED_T,
  parameter int WALK_T    = DEF_WALK_T
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_APP-1:0]         car,
  input  logic                       ped_button,
  output logic [NUM_APP-1:0]         red,
  output logic [NUM_APP-1:0]         yellow,
  output logic [NUM_APP-1:0]         green,
  output logic                       walk,
  output logic                       ped_wait,
  output state_t                     state,
  output logic [$clog2(NUM_APP)-1:0] phase
);

  localparam int PH_W = $clog2(NUM_APP);

  localparam logic [CNT_W-1:0] GMIN_LAST   = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST   = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_T - 1);
  localparam logic [PH_W-1:0]  LAST_APP    = PH_W'(NUM_APP - 1);

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              ped_req_q, ped_req_d;
  logic              ped_block_q, ped_block_d;
  logic [NUM_APP-1:0] red_q, red_d;
  logic [NUM_APP-1:0] yellow_q, yellow_d;
  logic [NUM_APP-1:0] green_q, green_d;
  logic              walk_q, walk_d;

  logic [CNT_W-1:0]  tmr;
  logic [CNT_W-1:0]  tmr_limit;
  logic              tmr_clr;

  logic [PH_W-1:0]   rr_phase;
  logic [PH_W-1:0]   rr_idx_b;
  int                rr_idx;
  logic              rr_found;
  logic [NUM_APP-1:0] phase_mask;
  logic              other_car;
  logic              conflict;
  logic              green_done;

  // The timer only needs to saturate while resting in green; other states
  // always leave before the count could wrap.
  assign tmr_limit = (state_q == S_GREEN) ? GMAX_LAST : '1;
  assign tmr_clr   = (state_d != state_q);

  phase_timer #(
    .CNT_W(CNT_W)
  ) u_phase_timer (
    .clock (clock),
    .reset (reset),
    .clr   (tmr_clr),
    .en    (1'b1),
    .limit (tmr_limit),
    .count (tmr)
  );

  // Round-robin search starting just after the current phase and wrapping
  // back to it; with no demand anywhere the phase simply advances by one.
  always_comb begin
    rr_phase = (phase_q == LAST_APP) ? '0 : phase_q + 1'b1;
    rr_found = 1'b0;
    rr_idx   = 0;
    rr_idx_b = '0;
    for (int i = 1; i <= NUM_APP; i++) begin
      rr_idx   = (int'(phase_q) + i) % NUM_APP;
      rr_idx_b = PH_W'(rr_idx);
      if (!rr_found && car[rr_idx_b]) begin
        rr_found = 1'b1;
        rr_phase = rr_idx_b;
      end
    end
  end

  always_comb begin
    phase_mask          = '0;
    phase_mask[phase_q] = 1'b1;
  end

  assign other_car = |(car & ~phase_mask);

`ifdef PED_PHASE_EN
  assign conflict = other_car | ped_req_q;
`else
  assign conflict = other_car;
  logic unused_ped;
  assign unused_ped = ped_button ^ ped_block_q;
`endif

  assign green_done = conflict && (tmr >= GMIN_LAST) &&
                      (!car[phase_q] || (tmr == GMAX_LAST));

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      S_ALLRED: begin
        if (tmr == ALLRED_LAST) begin
          if (ped_req_q) begin
            state_d = S_WALK;
          end else begin
            state_d = S_GREEN;
            phase_d = rr_phase;
          end
        end
      end
      S_GREEN: begin
        if (green_done) begin
          state_d = S_YELLOW;
        end
      end
      S_YELLOW: begin
        if (tmr == YELLOW_LAST) begin
          state_d = S_ALLRED;
        end
      end
      S_WALK: begin
        if (tmr == WALK_LAST) begin
          state_d = S_ALLRED;
        end
      end
      default: state_d = S_ALLRED;
    endcase
  end

  // Entry to walk clears the request even if the button is held on that edge;
  // ped_block keeps a press during walk or the following all-red from re-arming.
  always_comb begin
`ifdef PED_PHASE_EN
    ped_req_d   = ped_req_q;
    ped_block_d = ped_block_q;
    if ((state_d == S_WALK) && (state_q != S_WALK)) begin
      ped_req_d = 1'b0;
    end else if (ped_button && (state_q != S_WALK) && !ped_block_q) begin
      ped_req_d = 1'b1;
    end
    if ((state_q == S_WALK) && (state_d == S_ALLRED)) begin
      ped_block_d = 1'b1;
    end else if ((state_d == S_GREEN) && (state_q != S_GREEN)) begin
      ped_block_d = 1'b0;
    end
`else
    ped_req_d   = 1'b0;
    ped_block_d = 1'b0;
`endif
  end

  // Lamps are decoded from the next state so that the lamp flops always
  // mirror the registered state and phase.
  always_comb begin
    red_d    = '1;
    yellow_d = '0;
    green_d  = '0;
    if (state_d == S_GREEN) begin
      red_d[phase_d]   = 1'b0;
      green_d[phase_d] = 1'b1;
    end else if (state_d == S_YELLOW) begin
      red_d[phase_d]    = 1'b0;
      yellow_d[phase_d] = 1'b1;
    end
`ifdef PED_PHASE_EN
    walk_d = (state_d == S_WALK);
`else
    walk_d = 1'b0;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_ALLRED;
      phase_q     <= LAST_APP;
      ped_req_q   <= 1'b0;
      ped_block_q <= 1'b0;
      red_q       <= '1;
      yellow_q    <= '0;
      green_q     <= '0;
      walk_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      ped_req_q   <= ped_req_d;
      ped_block_q <= ped_block_d;
      red_q       <= red_d;
      yellow_q    <= yellow_d;
      green_q     <= green_d;
      walk_q      <= walk_d;
    end
  end

  assign red      = red_q;
  assign yellow   = yellow_q;
  assign green    = green_q;
  assign walk     = walk_q;
  assign ped_wait = ped_req_q;
  assign state    = state_q;
  assign phase    = phase_q;

endmodule

// File: tb/tb_signal_phase_ctrl.sv
// Directed bench for signal_phase_ctrl: reset, gap-out, max-out, pedestrian and reset-in-yellow.
// Cycle k is the interval after k clock edges following reset release.
module tb_signal_phase_ctrl;
  import signal_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] car;
  logic       ped_button;
  logic [3:0] red;
  logic [3:0] yellow;
  logic [3:0] green;
  logic       walk;
  logic       ped_wait;
  state_t     state;
  logic [1:0] phase;

  int testsRun    = 0;
  int testsFailed = 0;
  int cyc         = 0;

  signal_phase_ctrl #(
    .NUM_APP   (4),
    .CNT_W     (8),
    .GREEN_MIN (8),
    .GREEN_MAX (24),
    .YELLOW_T  (3),
    .ALLRED_T  (2),
    .WALK_T    (10)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .car        (car),
    .ped_button (ped_button),
    .red        (red),
    .yellow     (yellow),
    .green      (green),
    .walk       (walk),
    .ped_wait   (ped_wait),
    .state      (state),
    .phase      (phase)
  );

  always #5 clock = ~clock;

  // Every comparison funnels through here so the counts stay honest.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] c, input logic p);
    car        = c;
    ped_button = p;
  endtask

  task automatic stepCycle();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic runTo(input int target);
    while (cyc < target) stepCycle();
  endtask

  task automatic releaseReset();
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic resetDut();
    reset = 1'b1;
    applyStimulus(4'b0000, 1'b0);
    releaseReset();
  endtask

  // Expected lamps come from the expected state/phase, independent of the DUT.
  task automatic checkState(input string tag, input state_t st, input logic [1:0] ph,
                            input logic pw);
    logic [3:0] eRed;
    logic [3:0] eYel;
    logic [3:0] eGrn;
    string      t;
    eRed = 4'b1111;
    eYel = 4'b0000;
    eGrn = 4'b0000;
    if (st == S_GREEN) begin
      eRed[ph] = 1'b0;
      eGrn[ph] = 1'b1;
    end else if (st == S_YELLOW) begin
      eRed[ph] = 1'b0;
      eYel[ph] = 1'b1;
    end
    t = $sformatf("%s@%0d", tag, cyc);
    checkOutput({t, "_state"},   32'(state),    32'(st));
    checkOutput({t, "_phase"},   32'(phase),    32'(ph));
    checkOutput({t, "_red"},     32'(red),      32'(eRed));
    checkOutput({t, "_yellow"},  32'(yellow),   32'(eYel));
    checkOutput({t, "_green"},   32'(green),    32'(eGrn));
    checkOutput({t, "_walk"},    32'(walk),     32'(st == S_WALK));
    checkOutput({t, "_pedwait"}, 32'(ped_wait), 32'(pw));
  endtask

  // car[0] held, car[2] joins at cycle 5, car[0] leaves at cycle 12.
  task automatic runGapOut(input string tag, input int lastCyc, input bit togglePed);
    for (int k = 0; k <= lastCyc; k++) begin
      state_t     es;
      logic [1:0] ep;
      logic [3:0] c;
      if (k < 2) begin
        es = S_ALLRED; ep = 2'd3;
      end else if (k <= 12) begin
        es = S_GREEN;  ep = 2'd0;
      end else if (k <= 15) begin
        es = S_YELLOW; ep = 2'd0;
      end else if (k <= 17) begin
        es = S_ALLRED; ep = 2'd0;
      end else begin
        es = S_GREEN;  ep = 2'd2;
      end
      checkState(tag, es, ep, 1'b0);
      c = (k < 5) ? 4'b0001 : ((k < 12) ? 4'b0101 : 4'b0100);
      applyStimulus(c, togglePed ? k[0] : 1'b0);
      if (k < lastCyc) stepCycle();
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    applyStimulus(4'b0000, 1'b0);
    #3;
    checkState("in_reset", S_ALLRED, 2'd3, 1'b0);

    // Reset, no demand: two all-red cycles then resting green on approach 0.
    resetDut();
    checkState("idle", S_ALLRED, 2'd3, 1'b0);
    stepCycle();
    checkState("idle", S_ALLRED, 2'd3, 1'b0);
    stepCycle();
    checkState("idle", S_GREEN, 2'd0, 1'b0);
    runTo(40);
    checkState("idle_rest", S_GREEN, 2'd0, 1'b0);

    // Gap-out (in the build without pedestrians the button toggles throughout).
    resetDut();
`ifdef PED_PHASE_EN
    runGapOut("gap", 22, 1'b0);
`else
    runGapOut("gap_noped", 22, 1'b1);
`endif

    // Max-out: constant demand everywhere, 29-cycle period per approach.
    resetDut();
    applyStimulus(4'b1111, 1'b0);
    runTo(2);   checkState("max", S_GREEN,  2'd0, 1'b0);
    runTo(25);  checkState("max", S_GREEN,  2'd0, 1'b0);
    runTo(26);  checkState("max", S_YELLOW, 2'd0, 1'b0);
    runTo(29);  checkState("max", S_ALLRED, 2'd0, 1'b0);
    runTo(31);  checkState("max", S_GREEN,  2'd1, 1'b0);
    runTo(54);  checkState("max", S_GREEN,  2'd1, 1'b0);
    runTo(55);  checkState("max", S_YELLOW, 2'd1, 1'b0);
    runTo(60);  checkState("max", S_GREEN,  2'd2, 1'b0);
    runTo(89);  checkState("max", S_GREEN,  2'd3, 1'b0);
    runTo(118); checkState("max", S_GREEN,  2'd0, 1'b0);

`ifdef PED_PHASE_EN
    // Pedestrian: press with car[1] after min green, walk, then green 1.
    resetDut();
    runTo(12);
    checkState("ped", S_GREEN, 2'd0, 1'b0);
    applyStimulus(4'b0010, 1'b1);
    stepCycle();
    applyStimulus(4'b0010, 1'b0);
    checkState("ped", S_YELLOW, 2'd0, 1'b1);
    runTo(16); checkState("ped", S_ALLRED, 2'd0, 1'b1);
    runTo(17); checkState("ped", S_ALLRED, 2'd0, 1'b1);
    runTo(18); checkState("ped", S_WALK,   2'd0, 1'b0);
    runTo(20);
    applyStimulus(4'b0010, 1'b1);
    stepCycle();
    applyStimulus(4'b0010, 1'b0);
    checkState("ped_inwalk", S_WALK, 2'd0, 1'b0);
    runTo(27); checkState("ped", S_WALK,   2'd0, 1'b0);
    runTo(28); checkState("ped", S_ALLRED, 2'd0, 1'b0);
    applyStimulus(4'b0010, 1'b1);
    stepCycle();
    applyStimulus(4'b0010, 1'b0);
    checkState("ped_postwalk", S_ALLRED, 2'd0, 1'b0);
    runTo(30); checkState("ped", S_GREEN, 2'd1, 1'b0);
    runTo(31); checkState("ped", S_GREEN, 2'd1, 1'b0);
`endif

    // Reset asserted mid-yellow forces all-red before any clock edge.
    resetDut();
    runGapOut("pre_rst", 14, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkState("rst_yellow", S_ALLRED, 2'd3, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    releaseReset();
    checkState("restart", S_ALLRED, 2'd3, 1'b0);
    stepCycle();
    checkState("restart", S_ALLRED, 2'd3, 1'b0);
    stepCycle();
    checkState("restart", S_GREEN, 2'd0, 1'b0);
    runTo(30);
    checkState("restart", S_GREEN, 2'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/signal_phase_ctrl.md
# signal_phase_ctrl

Parametrised intersection controller for 2–4 signalled approaches plus an optional exclusive pedestrian phase. Successor to the fixed three-light chip controller. Adds:
- configurable approach count and phase durations;
- demand-driven round-robin service with min/max green and gap-out;
- latched pedestrian requests with anti-starvation.

It sits between the debounced/synchronised `io_in` detector bits and the lamp drivers on `io_out`.

## Interface
Parameters:
- `NUM_APP`, 4, number of approaches (2..4)
- `CNT_W`, 8, phase timer width
- `GREEN_MIN`, 8, minimum green cycles (≥1)
- `GREEN_MAX`, 24, maximum green cycles under conflicting demand (≥ `GREEN_MIN`)
- `YELLOW_T`, 3, yellow cycles (≥1)
- `ALLRED_T`, 2, all-red clearance cycles (≥1)
- `WALK_T`, 10, walk cycles (≥1)
- All durations must be < 2^`CNT_W`.

Ports:
- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `car`  in  `NUM_APP`  per-approach vehicle presence, synchronous to `clock`
- `ped_button`  in  1  pedestrian request, synchronous, level or pulse
- `red`  out  `NUM_APP`  red lamp per approach
- `yellow`  out  `NUM_APP`  yellow lamp per approach
- `green`  out  `NUM_APP`  green lamp per approach
- `walk`  out  1  pedestrian walk lamp
- `ped_wait`  out  1  request latched and not yet served
- `state`  out  2  current state (`state_t`)
- `phase`  out  $clog2(`NUM_APP`)  approach currently or last served

## Operation
- States: `S_ALLRED`, `S_GREEN`, `S_YELLOW`, `S_WALK`.
- `tmr` counts cycles spent in the current state and clears on every state change.
- Reset values:
  - `state`=`S_ALLRED`, `tmr`=0, `phase`=`NUM_APP`-1, `ped_req`=0, `ped_block`=0.
  - `red`=all ones; `yellow`, `green`, `walk`, `ped_wait` = 0.
- Lamps are a Moore decode of registered state and `phase`:
  - non-`phase` approaches are always red;
  - the `phase` approach is green in `S_GREEN`, yellow in `S_YELLOW`, red otherwise;
  - `walk`=1 only in `S_WALK`;
  - exactly one of red/yellow/green is set per approach at all times.
- `S_ALLRED` exits when `tmr`==`ALLRED_T`-1:
  - if `ped_req`, go to `S_WALK`;
  - else go to `S_GREEN` with `phase` set to the first j in `phase`+1, `phase`+2, …, `phase` (mod `NUM_APP`) with `car[j]`=1;
  - if no car is present anywhere, `phase`=`phase`+1 mod `NUM_APP`.
- `S_GREEN`:
  - conflict = `ped_req` OR any `car[j]` with j≠`phase`;
  - go to `S_YELLOW` when conflict AND `tmr` ≥ `GREEN_MIN`-1 AND (`car[phase]`=0 OR `tmr`==`GREEN_MAX`-1);
  - without conflict, rest in green indefinitely, with `tmr` saturating at `GREEN_MAX`-1.
- `S_YELLOW` goes to `S_ALLRED` when `tmr`==`YELLOW_T`-1.
- `S_WALK` goes to `S_ALLRED` when `tmr`==`WALK_T`-1 and sets `ped_block`. The post-walk all-red therefore always proceeds to a green.
- `ped_req` behaviour:
  - set on any cycle with `ped_button`=1, unless in `S_WALK` or `ped_block`=1;
  - cleared on entry to `S_WALK`;
  - `ped_block` clears on entry to `S_GREEN`;
  - `ped_wait` = `ped_req`.
- Simultaneous events:
  - a button press on the same edge that `S_ALLRED` exits is latched but not served that cycle;
  - `car` changes take effect on the next evaluated edge.

## Timing
- Outputs are registered state decodes. There is no combinational input→output path.
- Decision latency is one cycle: an input sampled at edge k affects outputs after edge k.
- From reset deassert with `car`=0, defaults: cycles 0–1 all red, then green on approach 0 from cycle 2.
- Each phase occupies exactly its parameter count of cycles.
- Reset asserted mid-phase forces all-red within the reset assertion, not at the next edge.

## Configuration
- `PED_PHASE_EN`:
  - **Defined:** the pedestrian latch and `S_WALK` are present as described.
  - **Undefined:** `ped_button` is ignored; `walk` and `ped_wait` are tied 0; `S_WALK` is unreachable; conflict considers cars only. Port list is unchanged.

## Structure
- Package `signal_pkg`:
  - `state_t` enum (`S_ALLRED`=0, `S_GREEN`=1, `S_YELLOW`=2, `S_WALK`=3);
  - default duration constants.
- Sub-module `phase_timer`: a `CNT_W` up-counter with synchronous clear, enable and saturation at a limit input. It is instantiated once.
- Round-robin selection and lamp decode live in the top module.

## Test plan
- **Reset, no demand:** defaults, `car`=0 → all red for 2 cycles, green 0 from cycle 2, resting indefinitely; `phase` stays 0.
- **Gap-out:** `car`=4'b0001 held, `car[2]` asserted at cycle 5, `car[0]` dropped at cycle 12 → yellow 0 after edge 12, 3 yellow, 2 all-red, green on approach 2.
- **Max-out:** `car`=4'b1111 constant → each green lasts 24 cycles, served order 0,1,2,3,0.
- **Pedestrian:** `ped_button` pulse during green 0 with `car[1]`=1, after min green → yellow, all-red, walk 10 cycles, all-red, green 1; a button pressed during walk or the post-walk all-red is not latched.
- **Reset mid-yellow:** assert `reset` in yellow → all lamps red, `walk`=0 immediately; after release the sequence restarts as in the first scenario.
- **Macro off:** build without `PED_PHASE_EN`, toggle `ped_button` → `walk` and `ped_wait` stay 0; the car sequence is identical to the gap-out scenario.
